// File: rtl/phy_rx_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_sync_if
// Brief    : Serial-in / aligned-byte-out bundle for the multi-lane receiver.
// Revision : 1.0  initial release
// ============================================================================
interface phy_rx_sync_if #(
    parameter int LANES = 2
);
    logic                 enable_i;
    logic [LANES-1:0]     serial_in_i;
    logic [8*LANES-1:0]   data_out_o;
    logic [LANES-1:0]     valid_out_o;
    logic [LANES-1:0]     byte_stb_o;
    logic [LANES-1:0]     lock_o;
    logic                 all_locked_o;

    modport master (
        output enable_i, serial_in_i,
        input  data_out_o, valid_out_o, byte_stb_o, lock_o, all_locked_o
    );

    modport slave (
        input  enable_i, serial_in_i,
        output data_out_o, valid_out_o, byte_stb_o, lock_o, all_locked_o
    );
endinterface
`default_nettype wire

// File: rtl/phy_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_sync
// Brief    : Per-lane deserialiser with comma hunt, lock and starvation re-hunt.
// Revision : 1.0  initial release
// ============================================================================
module phy_rx_sync #(
    parameter int         LANES      = 2,
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic          clk_8f,
    input  logic          reset,
    phy_rx_sync_if.slave  bus
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int GAP_W = $clog2(MAX_GAP + 2);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MAX_GAP);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic [LANES-1:0] lock_d;
    logic             all_locked_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Only 7 bits of history are needed: the window appends the live bit.
        logic [6:0]       sr_q;
        logic [7:0]       w;
        logic             is_comma;
        logic             boundary;
        state_t           state_q, state_d;
        logic [2:0]       bit_q, bit_d;
        logic [RUN_W-1:0] run_q, run_d;
        logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
        logic [7:0]       data_q, data_d;
        logic             valid_q, valid_d;
        logic             stb_q, stb_d;
        logic             lock_q;

        assign w        = {sr_q, bus.serial_in_i[i]};
        assign is_comma = (w == COMMA);
        assign boundary = (bit_q == 3'd7);
        assign gap_inc  = gap_q + GAP_ONE;

        always_comb begin
            state_d = state_q;
            bit_d   = bit_q + 3'd1;
            run_d   = run_q;
            gap_d   = gap_q;
            data_d  = data_q;
            valid_d = valid_q;
            stb_d   = 1'b0;
            if (!bus.enable_i) begin
                state_d = HUNT;
                bit_d   = '0;
                run_d   = '0;
                gap_d   = '0;
                valid_d = 1'b0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        bit_d   = '0;
                        valid_d = 1'b0;
                        if (is_comma) begin
                            run_d   = RUN_ONE;
                            gap_d   = '0;
                            state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                        end
                    end
                    SYNC: begin
                        if (boundary) begin
                            if (is_comma) begin
                                run_d = run_q + RUN_ONE;
                                if (run_d == RUN_LOCK) begin
                                    state_d = LOCKED;
                                    gap_d   = '0;
                                end
                            end else begin
                                state_d = HUNT;
                                run_d   = '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
                            stb_d   = 1'b1;
                            data_d  = w;
                            valid_d = !is_comma;
                            if (is_comma) begin
                                gap_d = '0;
                            end else if (gap_inc > GAP_MAX) begin
                                // Starved byte is still strobed, but flagged invalid.
                                state_d = HUNT;
                                valid_d = 1'b0;
                                gap_d   = '0;
                                run_d   = '0;
                            end else begin
                                gap_d = gap_inc;
                            end
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        assign lock_d[i] = (state_d == LOCKED);

        always_ff @(posedge clk_8f or posedge reset) begin
            if (reset) begin
                sr_q    <= '0;
                state_q <= HUNT;
                bit_q   <= '0;
                run_q   <= '0;
                gap_q   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                stb_q   <= 1'b0;
                lock_q  <= 1'b0;
            end else begin
                sr_q    <= w[6:0];
                state_q <= state_d;
                bit_q   <= bit_d;
                run_q   <= run_d;
                gap_q   <= gap_d;
                data_q  <= data_d;
                valid_q <= valid_d;
                stb_q   <= stb_d;
                lock_q  <= lock_d[i];
            end
        end

        assign bus.data_out_o[8*i +: 8] = data_q;
        assign bus.valid_out_o[i]       = valid_q;
        assign bus.byte_stb_o[i]        = stb_q;
        assign bus.lock_o[i]            = lock_q;
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &lock_d;
        end
    end

    assign bus.all_locked_o = all_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_sync
// Brief    : Scoreboard bench for phy_rx_sync (2 lanes, comma BC, lock 4, gap 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_phy_rx_sync;

    localparam int LANES = 2;

    logic clk_8f = 1'b0;
    logic reset;

    always #5 clk_8f = ~clk_8f;

    phy_rx_sync_if #(.LANES(LANES)) bus ();

    phy_rx_sync #(
        .LANES      (LANES),
        .COMMA      (8'hBC),
        .LOCK_COUNT (4),
        .MAX_GAP    (16)
    ) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   bq0[$];
    bit   bq1[$];
    exp_t e0, e1;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_bits(input int lane, input logic [7:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            if (lane == 0) bq0.push_back(bits[k]);
            else           bq1.push_back(bits[k]);
        end
    endtask

    task automatic send(input int lane, input logic [7:0] b, input bit expect_out, input bit vld);
        exp_t e;
        e.d = b;
        e.v = vld;
        push_bits(lane, b, 8);
        if (expect_out) begin
            if (lane == 0) exp_q0.push_back(e);
            else           exp_q1.push_back(e);
        end
    endtask

    // Bits go out on the falling edge; returns 2 time units after the last sampling edge.
    task automatic run(input int n);
        bit b0, b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_8f);
            b0 = (bq0.size() != 0) ? bq0.pop_front() : 1'b0;
            b1 = (bq1.size() != 0) ? bq1.pop_front() : 1'b0;
            bus.serial_in_i = {b1, b0};
        end
        @(posedge clk_8f);
        #2;
    endtask

    task automatic drain();
        int n;
        n = (bq0.size() > bq1.size()) ? bq0.size() : bq1.size();
        if (n > 0) run(n);
    endtask

    task automatic check_lock(input string tag, input logic [1:0] lk, input logic al);
        check_val({tag, "_lock"}, 32'(bus.lock_o), 32'(lk));
        check_val({tag, "_all"},  32'(bus.all_locked_o), 32'(al));
    endtask

    always @(posedge clk_8f) begin
        #1;
        if (bus.byte_stb_o[0]) begin
            if (exp_q0.size() == 0) begin
                check_val("stb0_unexpected", 32'(bus.byte_stb_o[0]), 32'd0);
            end else begin
                e0 = exp_q0.pop_front();
                check_val("data0",  32'(bus.data_out_o[7:0]), 32'(e0.d));
                check_val("valid0", 32'(bus.valid_out_o[0]),  32'(e0.v));
            end
        end
        if (bus.byte_stb_o[1]) begin
            if (exp_q1.size() == 0) begin
                check_val("stb1_unexpected", 32'(bus.byte_stb_o[1]), 32'd0);
            end else begin
                e1 = exp_q1.pop_front();
                check_val("data1",  32'(bus.data_out_o[15:8]), 32'(e1.d));
                check_val("valid1", 32'(bus.valid_out_o[1]),   32'(e1.v));
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.enable_i    = 1'b1;
        bus.serial_in_i = '0;
        repeat (2) @(posedge clk_8f);
        #2;
        check_val("rst_data",  32'(bus.data_out_o),  32'd0);
        check_val("rst_valid", 32'(bus.valid_out_o), 32'd0);
        check_val("rst_stb",   32'(bus.byte_stb_o),  32'd0);
        check_lock("rst", 2'b00, 1'b0);
        reset = 1'b0;

        // Basic lock, lanes carrying different payloads.
        for (int k = 0; k < 4; k++) begin
            send(0, 8'hBC, 1'b0, 1'b0);
            send(1, 8'hBC, 1'b0, 1'b0);
        end
        send(0, 8'hAA, 1'b1, 1'b1);
        send(0, 8'hDD, 1'b1, 1'b1);
        send(1, 8'hBB, 1'b1, 1'b1);
        send(1, 8'hDE, 1'b1, 1'b1);
        run(31);
        check_lock("pre_lock", 2'b00, 1'b0);
        run(1);
        check_lock("lock", 2'b11, 1'b1);
        check_val("lock_edge_stb", 32'(bus.byte_stb_o), 32'd0);
        drain();
        check_lock("lock_end", 2'b11, 1'b1);

        // Idle comma between data bytes.
        for (int l = 0; l < 2; l++) begin
            send(l, 8'h88, 1'b1, 1'b1);
            send(l, 8'hBC, 1'b1, 1'b0);
            send(l, 8'h77, 1'b1, 1'b1);
        end
        drain();
        check_lock("idle", 2'b11, 1'b1);

        // Starvation on lane 0: 17 non-comma bytes after a comma.
        send(0, 8'hBC, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) send(0, 8'(8'h20 + k), 1'b1, 1'b1);
        send(0, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 18; k++) send(1, 8'hBC, 1'b1, 1'b0);
        drain();
        check_lock("starve", 2'b10, 1'b0);

        for (int k = 0; k < 4; k++) send(0, 8'hBC, 1'b0, 1'b0);
        send(0, 8'h99, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) send(1, 8'hBC, 1'b1, 1'b0);
        drain();
        check_lock("relock", 2'b11, 1'b1);

        // Enable dropped while locked.
        bus.enable_i = 1'b0;
        run(1);
        check_lock("dis", 2'b00, 1'b0);
        check_val("dis_valid", 32'(bus.valid_out_o), 32'd0);
        check_val("dis_stb",   32'(bus.byte_stb_o),  32'd0);
        run(7);
        check_lock("dis_hold", 2'b00, 1'b0);
        bus.enable_i = 1'b1;

        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 4; k++) send(l, 8'hBC, 1'b0, 1'b0);
            send(l, 8'h33, 1'b1, 1'b1);
        end
        drain();
        check_lock("en_relock", 2'b11, 1'b1);
        check_val("en_data", 32'(bus.data_out_o), 32'h3333);

        // Asynchronous reset in the middle of a byte.
        send(0, 8'h55, 1'b0, 1'b0);
        send(1, 8'h55, 1'b0, 1'b0);
        run(3);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_data",  32'(bus.data_out_o),  32'd0);
        check_val("mid_rst_valid", 32'(bus.valid_out_o), 32'd0);
        check_val("mid_rst_stb",   32'(bus.byte_stb_o),  32'd0);
        check_lock("mid_rst", 2'b00, 1'b0);
        bq0.delete();
        bq1.delete();
        bus.serial_in_i = '0;
        repeat (2) @(posedge clk_8f);
        #2 reset = 1'b0;

        // Lane 0 short comma run then full run; lane 1 skewed by 3 bits.
        for (int k = 0; k < 3; k++) send(0, 8'hBC, 1'b0, 1'b0);
        send(0, 8'hAA, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send(0, 8'hBC, 1'b0, 1'b0);
        send(0, 8'h99, 1'b1, 1'b1);
        send(0, 8'hBC, 1'b1, 1'b0);
        send(0, 8'hBC, 1'b1, 1'b0);
        push_bits(1, 8'b0000_0101, 3);
        for (int k = 0; k < 4; k++) send(1, 8'hBC, 1'b0, 1'b0);
        send(1, 8'h11, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) send(1, 8'hBC, 1'b1, 1'b0);
        run(40);
        check_lock("short_run", 2'b10, 1'b0);
        run(23);
        check_lock("pre_all", 2'b10, 1'b0);
        run(1);
        check_lock("all", 2'b11, 1'b1);
        drain();
        repeat (2) @(posedge clk_8f);
        #2;
        check_val("left0", 32'(exp_q0.size()), 32'd0);
        check_val("left1", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
